// File: rtl/ref_pos_stream_buffer.sv
// Multi-channel reference-particle position buffer: sequential fill from the cell loader,
// then valid/ready streaming of all stored entries through a latency-hiding output FIFO.
module ref_pos_stream_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_CH      = 3,
  parameter int DEPTH       = 512,
  parameter int ADDR_WIDTH  = 9,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                           clock,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           wr_en,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
  input  logic                           start,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH-1:0]          out_addr,
  output logic                           out_last,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           full,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int W  = NUM_CH * DATA_WIDTH;
  localparam int PW = $clog2(OFIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH   = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] C_ZERO    = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [PW+1:0]       C_OFD     = OFIFO_DEPTH[PW+1:0];
  localparam logic [PW-1:0]       C_PTR_ONE = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW:0]         C_OCC_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t                r_state;
  logic [W-1:0]          r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_count, r_n, r_rd_ptr;
  logic                  r_overflow, r_done;
  logic                  r_a_vld, r_a_last, r_q_vld, r_q_last;
  logic [ADDR_WIDTH-1:0] r_a_addr, r_q_addr;
  logic [W-1:0]          r_q_data;
  logic [W-1:0]          r_f_data [OFIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_f_addr [OFIFO_DEPTH];
  logic [OFIFO_DEPTH-1:0] r_f_last;
  logic [PW-1:0]         r_f_wptr, r_f_rptr;
  logic [PW:0]           r_f_occ;

  logic                  w_busy, w_full, w_wr_ok, w_wr_bad, w_last_ptr, w_issue, w_pop, w_out_valid;
  logic [PW+1:0]         w_load;

  assign w_busy      = (r_state != S_IDLE);
  assign w_full      = (r_count == C_DEPTH);
  assign w_wr_ok     = wr_en && !clear && !w_full && !w_busy;
  assign w_wr_bad    = wr_en && !clear && (w_full || w_busy);
  assign w_last_ptr  = (r_rd_ptr == (r_n - C_ONE));
  // Reads already in the pipe count against FIFO space so the FIFO can never overflow.
  assign w_load      = {1'b0, r_f_occ} + {{(PW+1){1'b0}}, r_a_vld} + {{(PW+1){1'b0}}, r_q_vld};
  assign w_issue     = (r_state == S_STREAM) && !clear && (w_load < C_OFD);
  assign w_out_valid = (r_f_occ != {(PW+1){1'b0}});
  assign w_pop       = w_out_valid && out_ready;

  // Control FSM, fill counter and status flags.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= C_ZERO;
      r_n        <= C_ZERO;
      r_rd_ptr   <= C_ZERO;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else if (clear) begin
      r_state    <= S_IDLE;
      r_count    <= C_ZERO;
      r_rd_ptr   <= C_ZERO;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_wr_ok)  r_count    <= r_count + C_ONE;
      if (w_wr_bad) r_overflow <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (r_count == C_ZERO) begin
              r_done <= 1'b1;
            end else begin
              r_n      <= r_count;
              r_rd_ptr <= C_ZERO;
              r_state  <= S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + C_ONE;
            if (w_last_ptr) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && out_last) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Block RAM: write port plus registered read of the issued address.
  always_ff @(posedge clock) begin
    if (w_wr_ok) r_mem[r_count[ADDR_WIDTH-1:0]] <= wr_data;
    r_q_data <= r_mem[r_a_addr];
  end

  // Read-tag pipeline and output FIFO.
  always_ff @(posedge clock) begin
    if (rst) begin
      r_a_vld  <= 1'b0;
      r_a_last <= 1'b0;
      r_a_addr <= {ADDR_WIDTH{1'b0}};
      r_q_vld  <= 1'b0;
      r_q_last <= 1'b0;
      r_q_addr <= {ADDR_WIDTH{1'b0}};
      r_f_wptr <= {PW{1'b0}};
      r_f_rptr <= {PW{1'b0}};
      r_f_occ  <= {(PW+1){1'b0}};
      r_f_last <= {OFIFO_DEPTH{1'b0}};
      for (int i = 0; i < OFIFO_DEPTH; i++) begin
        r_f_data[i] <= {W{1'b0}};
        r_f_addr[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else if (clear) begin
      r_a_vld  <= 1'b0;
      r_q_vld  <= 1'b0;
      r_f_wptr <= {PW{1'b0}};
      r_f_rptr <= {PW{1'b0}};
      r_f_occ  <= {(PW+1){1'b0}};
    end else begin
      r_a_vld <= w_issue;
      if (w_issue) begin
        r_a_addr <= r_rd_ptr[ADDR_WIDTH-1:0];
        r_a_last <= w_last_ptr;
      end
      r_q_vld  <= r_a_vld;
      r_q_addr <= r_a_addr;
      r_q_last <= r_a_last;
      if (r_q_vld) begin
        r_f_data[r_f_wptr] <= r_q_data;
        r_f_addr[r_f_wptr] <= r_q_addr;
        r_f_last[r_f_wptr] <= r_q_last;
        r_f_wptr           <= r_f_wptr + C_PTR_ONE;
      end
      if (w_pop) r_f_rptr <= r_f_rptr + C_PTR_ONE;
      case ({r_q_vld, w_pop})
        2'b10:   r_f_occ <= r_f_occ + C_OCC_ONE;
        2'b01:   r_f_occ <= r_f_occ - C_OCC_ONE;
        default: r_f_occ <= r_f_occ;
      endcase
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = r_f_data[r_f_rptr];
  assign out_addr  = r_f_addr[r_f_rptr];
  assign out_last  = w_out_valid && r_f_last[r_f_rptr];
  assign count     = r_count;
  assign full      = w_full;
  assign busy      = w_busy;
  assign done      = r_done;
  assign overflow  = r_overflow;

endmodule
